pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Purpose : Hack program counter with jump resolution, registered ALU flags and an
//           optional self-jump halt detector (enabled by macro PC_UNIT_HALT_DETECT_EN).
// Latency : 1 cycle; pc/flags/jump_taken reflect an accepted instruction the next cycle.
// Backpr. : stall freezes all state; valid_in low or HALTED state also hold every output.
module pc_unit #(
  parameter int HALT_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        is_c_instr,
  input  logic [2:0]  jump_bits,
  input  logic [15:0] alu_out,
  input  logic [15:0] a_reg,
  output logic [15:0] pc,
  output logic        jump_taken,
  output logic        zr,
  output logic        ng,
  output logic        halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // The counter is 4 bits wide, so only 1..15 is a reachable halt threshold.
  if (HALT_COUNT < 1 || HALT_COUNT > 15) begin : g_halt_count_range
    $error("pc_unit: HALT_COUNT must be in 1..15");
  end

  state_t state;
  state_t state_nxt;

  logic zero;
  logic neg;
  logic cond;
  logic accept;

  // Flags of the current ALU result and the Hack jump condition.
  always_comb begin
    zero   = (alu_out == 16'h0000);
    neg    = alu_out[15];
    cond   = is_c_instr & ((jump_bits[2] & neg) |
                           (jump_bits[1] & zero) |
                           (jump_bits[0] & ~neg & ~zero));
    accept = valid_in & ~stall & (state == RUN);
  end

`ifdef PC_UNIT_HALT_DETECT_EN
  localparam logic [3:0] HALT_LIMIT = 4'(HALT_COUNT);

  logic [3:0] halt_cnt;
  logic [3:0] halt_cnt_nxt;

  // Count back-to-back taken jumps onto the current pc; reaching the limit halts.
  always_comb begin
    state_nxt    = state;
    halt_cnt_nxt = halt_cnt;
    if (accept) begin
      if (cond && (a_reg == pc)) begin
        halt_cnt_nxt = halt_cnt + 4'd1;
        if (halt_cnt_nxt == HALT_LIMIT) begin
          state_nxt = HALTED;
        end
      end else begin
        halt_cnt_nxt = 4'd0;
      end
    end
  end

  // State register and self-jump counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      halt_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      halt_cnt <= halt_cnt_nxt;
    end
  end

  assign halted = (state == HALTED);
`else
  // Without the halt detector the machine never leaves RUN.
  always_comb begin
    state_nxt = RUN;
  end

  // State register (held at RUN).
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  assign halted = 1'b0;
`endif

  // Program counter, jump indication and flag registers; update only on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= 16'h0000;
      jump_taken <= 1'b0;
      zr         <= 1'b0;
      ng         <= 1'b0;
    end else if (accept) begin
      pc         <= cond ? a_reg : (pc + 16'h0001);
      jump_taken <= cond;
      zr         <= zero;
      ng         <= neg;
    end
  end

endmodule
